servo_ramp_ctrl: RTL and testbench

//  Multi-channel scheduler for SimpleServo instances: holds per-channel target positions,

---
 rtl/servo_pkg.sv | 34 +++
 rtl/servo_frame_tick.sv | 32 +++
 rtl/servo_ramp_ctrl.sv | 140 ++++++++++++++
 tb/tb_servo_ramp_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo ramp scheduler and related servo blocks.
package servo_pkg;

   localparam int unsigned MS_NS     = 1_000_000;
   localparam int unsigned POS_MAX_W = 16;

   typedef enum logic {
      S_IDLE,
      S_UPDATE
   } state_e;

   function automatic int unsigned frame_clocks(input int unsigned clk_per_ns,
                                                input int unsigned frame_ms);
      return (frame_ms * MS_NS) / clk_per_ns;
   endfunction

   // Moves pos toward tgt by at most step; the extra top bit keeps the distance
   // and the sum exact, so the result always lands between pos and tgt.
   function automatic logic [POS_MAX_W-1:0] ramp_step(input logic [POS_MAX_W-1:0] pos,
                                                      input logic [POS_MAX_W-1:0] tgt,
                                                      input logic [POS_MAX_W-1:0] step);
      logic [POS_MAX_W:0] d;
      logic [POS_MAX_W:0] nxt;
      if (tgt >= pos) begin
         d   = {1'b0, tgt} - {1'b0, pos};
         nxt = (d <= {1'b0, step}) ? {1'b0, tgt} : ({1'b0, pos} + {1'b0, step});
      end else begin
         d   = {1'b0, pos} - {1'b0, tgt};
         nxt = (d <= {1'b0, step}) ? {1'b0, tgt} : ({1'b0, pos} - {1'b0, step});
      end
      return nxt[POS_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/servo_frame_tick.sv
// Free-running frame counter: one-cycle tick_o every frame_clocks() clocks.
module servo_frame_tick
   import servo_pkg::*;
#(
   parameter int unsigned CLK_PER_NS = 40,
   parameter int unsigned FRAME_MS   = 20
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int unsigned   FC   = frame_clocks(CLK_PER_NS, FRAME_MS);
   localparam int unsigned   CW   = (FC > 1) ? $clog2(FC) : 1;
   localparam logic [CW-1:0] LAST = CW'(FC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // NOTE: every signal assigned in always_comb gets a value on every path, or a latch is inferred.
   always_comb begin
      tick_o = (cnt_q == LAST);
      cnt_d  = tick_o ? '0 : (cnt_q + CW'(1));
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Per-channel target/position scheduler that slews servo positions once per frame.
// Optional done_o pulse when built with SERVO_RAMP_DONE_EN defined.
module servo_ramp_ctrl
   import servo_pkg::*;
#(
   parameter int unsigned CLK_PER_NS = 40,
   parameter int unsigned N          = 8,
   parameter int unsigned NCH        = 4,
   parameter int unsigned FRAME_MS   = 20
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   input  logic [3:0]       wr_ch_i,
   input  logic             wr_en_i,
   input  logic [N-1:0]     wr_pos_i,
   input  logic [N-1:0]     step_i,
   output logic [NCH*N-1:0] position_o,
   output logic [NCH-1:0]   en_o,
`ifdef SERVO_RAMP_DONE_EN
   output logic             done_o,
`endif
   output logic             busy_o
);

   localparam int unsigned     CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);
   localparam logic [N-1:0]    MID     = {1'b1, {(N-1){1'b0}}};

   state_e                  state_q;
   logic [CH_W-1:0]         ch_q;
   logic [N-1:0]            step_q;
   logic                    tick_pending_q;
   logic [NCH-1:0][N-1:0]   pos_q;
   logic [NCH-1:0][N-1:0]   tgt_q;
   logic [NCH-1:0]          en_q;
   logic                    busy_q;
   logic                    ready_q;

   logic                    tick;
   logic                    wr_fire;
   logic [N-1:0]            cur_pos;
   logic [N-1:0]            cur_tgt;
   logic [N-1:0]            nxt_pos;
   logic                    busy_d;

   servo_frame_tick #(
      .CLK_PER_NS (CLK_PER_NS),
      .FRAME_MS   (FRAME_MS)
   ) u_frame_tick (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick_o (tick)
   );

   assign wr_fire = wr_valid_i && ready_q;

   // A single ramp unit is shared by all channels through the slot mux.
   always_comb begin
      cur_pos = '0;
      cur_tgt = '0;
      busy_d  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (ch_q == CH_W'(k)) begin
            cur_pos = pos_q[k];
            cur_tgt = tgt_q[k];
         end
         busy_d = busy_d | (en_q[k] && (pos_q[k] != tgt_q[k]));
      end
      nxt_pos = N'(ramp_step(POS_MAX_W'(cur_pos), POS_MAX_W'(cur_tgt), POS_MAX_W'(step_q)));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_IDLE;
         ch_q           <= '0;
         step_q         <= '0;
         tick_pending_q <= 1'b0;
         // NOTE: the position/target arrays are small register files that must come up at midscale, so they are reset like any other flop.
         pos_q          <= {NCH{MID}};
         tgt_q          <= {NCH{MID}};
         en_q           <= '0;
         busy_q         <= 1'b0;
         ready_q        <= 1'b0;
      end else begin
         busy_q <= busy_d;
         unique case (state_q)
            S_IDLE: begin
               if (wr_fire) begin
                  for (int k = 0; k < NCH; k++) begin
                     if (wr_ch_i == 4'(k)) begin
                        if (wr_en_i) tgt_q[k] <= wr_pos_i;
                        en_q[k] <= wr_en_i;
                     end
                  end
               end
               if (tick || tick_pending_q) begin
                  state_q        <= S_UPDATE;
                  ch_q           <= '0;
                  step_q         <= step_i;
                  tick_pending_q <= 1'b0;
                  ready_q        <= 1'b0;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_UPDATE: begin
               if (tick) tick_pending_q <= 1'b1;
               for (int k = 0; k < NCH; k++) begin
                  if ((ch_q == CH_W'(k)) && en_q[k]) pos_q[k] <= nxt_pos;
               end
               if (ch_q == LAST_CH) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
               end else begin
                  ch_q <= ch_q + CH_W'(1);
               end
            end
         endcase
      end
   end

`ifdef SERVO_RAMP_DONE_EN
   logic done_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) done_q <= 1'b0;
      else         done_q <= busy_q && !busy_d;
   end

   assign done_o = done_q;
`endif

   assign wr_ready_o = ready_q;
   assign position_o = pos_q;
   assign en_o       = en_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with 50-clock frames (CLK_PER_NS=20000, FRAME_MS=1).
module tb_servo_ramp_ctrl;

   localparam int unsigned N   = 8;
   localparam int unsigned NCH = 4;

   logic             clk = 1'b0;
   logic             rst_ni = 1'b0;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic [3:0]       wr_ch = '0;
   logic             wr_en = 1'b0;
   logic [N-1:0]     wr_pos = '0;
   logic [N-1:0]     step = '0;
   logic [NCH*N-1:0] position;
   logic [NCH-1:0]   en;
   logic             busy;
`ifdef SERVO_RAMP_DONE_EN
   logic             done;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   servo_ramp_ctrl #(
      .CLK_PER_NS (20000),
      .N          (N),
      .NCH        (NCH),
      .FRAME_MS   (1)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .wr_valid_i (wr_valid),
      .wr_ready_o (wr_ready),
      .wr_ch_i    (wr_ch),
      .wr_en_i    (wr_en),
      .wr_pos_i   (wr_pos),
      .step_i     (step),
      .position_o (position),
      .en_o       (en),
`ifdef SERVO_RAMP_DONE_EN
      .done_o     (done),
`endif
      .busy_o     (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Steps negedge by negedge until wr_ready_o reaches level, within budget cycles.
   task automatic wait_ready(input logic level, input int budget, input string tag);
      int n = 0;
      while (wr_ready !== level && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(wr_ready), 32'(level));
   endtask

   // Waits for the next full frame update plus one cycle for busy_o to settle.
   task automatic wait_frame();
      wait_ready(1'b0, 120, "frame_start");
      wait_ready(1'b1, 20, "frame_end");
      @(negedge clk);
   endtask

   // Called at a negedge; presents the write immediately and returns at the negedge after acceptance.
   task automatic do_write(input logic [3:0] ch, input logic en_bit, input logic [7:0] pos);
      wr_valid = 1'b1;
      wr_ch    = ch;
      wr_en    = en_bit;
      wr_pos   = pos;
      wait_ready(1'b1, 20, "wr_accept");
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   initial begin
      int low_cnt;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_position", position, 32'h8080_8080);
      check("rst_en", 32'(en), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ready", 32'(wr_ready), 32'h0);
      rst_ni = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(wr_ready), 32'h1);

      // Ramp ch1 0x80 -> 0xA0 in steps of 0x10
      step = 8'h10;
      do_write(4'd1, 1'b1, 8'hA0);
      check("ch1_en", 32'(en), 32'h2);
      @(negedge clk);
      check("ch1_busy", 32'(busy), 32'h1);
      wait_frame();
      check("ch1_frame1", position, 32'h8080_9080);
      check("ch1_busy_f1", 32'(busy), 32'h1);
      wait_frame();
      check("ch1_frame2", position, 32'h8080_A080);
      check("ch1_settled", 32'(busy), 32'h0);

      // Step larger than distance, then full-scale step down to zero
      step = 8'h20;
      do_write(4'd0, 1'b1, 8'h7C);
      wait_frame();
      check("ch0_snap", position, 32'h8080_A07C);
      step = 8'hFF;
      do_write(4'd0, 1'b1, 8'h00);
      wait_frame();
      check("ch0_no_wrap", position, 32'h8080_A000);
      check("ch0_busy", 32'(busy), 32'h0);

      // Write presented during S_UPDATE is held off for NCH cycles
      wait_ready(1'b0, 120, "upd_start");
      low_cnt  = 1;
      wr_valid = 1'b1;
      wr_ch    = 4'd3;
      wr_en    = 1'b1;
      wr_pos   = 8'h90;
      while (low_cnt < 20) begin
         @(negedge clk);
         if (wr_ready) break;
         low_cnt++;
      end
      check("ready_low_cycles", 32'(low_cnt), 32'(NCH));
      @(negedge clk);
      wr_valid = 1'b0;
      check("ch3_en", 32'(en), 32'hB);
      check("ch3_pos_hold", position, 32'h8080_A000);
      wait_frame();
      check("ch3_moved", position, 32'h9080_A000);

      // Write coincident with the tick: the new target is used in that frame
      step = 8'h10;
      wait_ready(1'b0, 120, "sync_start");
      repeat (49) @(negedge clk);
      do_write(4'd2, 1'b1, 8'h40);
      check("coincident_frame", 32'(wr_ready), 32'h0);
      wait_ready(1'b1, 20, "coincident_end");
      @(negedge clk);
      check("ch2_same_frame", position, 32'h9070_A000);
      check("ch2_busy", 32'(busy), 32'h1);

      // Disable ch2 mid-ramp
      do_write(4'd2, 1'b0, 8'h00);
      check("ch2_disabled", 32'(en), 32'hB);
      @(negedge clk);
      check("busy_after_dis", 32'(busy), 32'h0);
      wait_frame();
      check("ch2_frozen", position, 32'h9070_A000);

      // Out-of-range channel: accepted, no state change
      do_write(4'd4, 1'b1, 8'h11);
      check("bad_ch_en", 32'(en), 32'hB);
      wait_frame();
      check("bad_ch_pos", position, 32'h9070_A000);
      check("bad_ch_busy", 32'(busy), 32'h0);

      // Asynchronous reset in the middle of S_UPDATE
      wait_ready(1'b0, 120, "rst_upd_start");
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_position", position, 32'h8080_8080);
      check("async_en", 32'(en), 32'h0);
      check("async_busy", 32'(busy), 32'h0);
      check("async_ready", 32'(wr_ready), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
